// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

    // Read-port modes for the FWFT parameter
    localparam int FWFT_OFF = 0;  // registered read, dout updates after an accepted read
    localparam int FWFT_ON  = 1;  // head word presented on dout while not empty

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_adv.sv
// Synchronous FIFO with occupancy/programmable flags, error pulses and FWFT or registered read.
module sync_fifo_adv
    import fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int FWFT    = FWFT_ON,
    localparam int CNT_W  = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    input  logic [CNT_W-1:0]  prog_full_thr,
    input  logic [CNT_W-1:0]  prog_empty_thr,
    output logic              prog_full,
    output logic              prog_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [CNT_W-1:0]  data_count
);

    localparam int ADDR_W = CNT_W - 1;

    // MSB of each pointer is a wrap bit; the low bits address the RAM and wrap naturally
    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rdata;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (din),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle pulses flagging rejected requests
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    // Flags depend only on the registered count (plus the live thresholds)
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_W'(DEPTH - 1));
    assign almost_empty = (r_count <= CNT_W'(1));
    assign prog_full    = (r_count >= prog_full_thr);
    assign prog_empty   = (r_count <= prog_empty_thr);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign data_count   = r_count;

    if (FWFT != FWFT_OFF) begin : g_fwft
        assign dout  = w_rdata;
        assign valid = !w_empty;
    end else begin : g_std
        logic [DATA_W-1:0] r_dout;
        logic              r_valid;

        // Registered read: capture the head word on an accepted read, hold otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= w_rdata;
                end
            end
        end

        assign dout  = r_dout;
        assign valid = r_valid;
    end

endmodule

// File: tb/tb_sync_fifo_adv.sv
// Self-checking bench: an FWFT and a registered-read FIFO driven with identical stimulus,
// checked against a queue-based reference model plus a table of hand-derived vectors.
module tb_sync_fifo_adv;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [CW-1:0] pft;
    logic [CW-1:0] pet;

    logic [DW-1:0] f_dout, s_dout;
    logic          f_valid, s_valid;
    logic          f_full, s_full, f_empty, s_empty;
    logic          f_af, s_af, f_ae, s_ae, f_pf, s_pf, f_pe, s_pe;
    logic          f_ov, s_ov, f_un, s_un;
    logic [CW-1:0] f_cnt, s_cnt;

    sync_fifo_adv #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .din            (din),
        .rd_en          (rd_en),
        .dout           (f_dout),
        .valid          (f_valid),
        .full           (f_full),
        .empty          (f_empty),
        .almost_full    (f_af),
        .almost_empty   (f_ae),
        .prog_full_thr  (pft),
        .prog_empty_thr (pet),
        .prog_full      (f_pf),
        .prog_empty     (f_pe),
        .overflow       (f_ov),
        .underflow      (f_un),
        .data_count     (f_cnt)
    );

    sync_fifo_adv #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .din            (din),
        .rd_en          (rd_en),
        .dout           (s_dout),
        .valid          (s_valid),
        .full           (s_full),
        .empty          (s_empty),
        .almost_full    (s_af),
        .almost_empty   (s_ae),
        .prog_full_thr  (pft),
        .prog_empty_thr (pet),
        .prog_full      (s_pf),
        .prog_empty     (s_pe),
        .overflow       (s_ov),
        .underflow      (s_un),
        .data_count     (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: contents as a queue, pulses and registered-read output as plain state
    logic [DW-1:0] q[$];
    logic          exp_ov, exp_un, exp_svalid;
    logic [DW-1:0] exp_sdout;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          full;
        logic          empty;
        logic          ov;
        logic          un;
        logic          chk_dout;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("f_count", 32'(f_cnt), n);
        chk("s_count", 32'(s_cnt), n);
        chk("f_full", f_full, n == DEPTH);
        chk("s_full", s_full, n == DEPTH);
        chk("f_empty", f_empty, n == 0);
        chk("s_empty", s_empty, n == 0);
        chk("f_almost_full", f_af, n >= DEPTH - 1);
        chk("f_almost_empty", f_ae, n <= 1);
        chk("f_prog_full", f_pf, n >= int'(pft));
        chk("f_prog_empty", f_pe, n <= int'(pet));
        chk("s_prog_full", s_pf, n >= int'(pft));
        chk("s_prog_empty", s_pe, n <= int'(pet));
        chk("f_overflow", f_ov, exp_ov);
        chk("f_underflow", f_un, exp_un);
        chk("s_overflow", s_ov, exp_ov);
        chk("s_underflow", s_un, exp_un);
        chk("f_valid", f_valid, n > 0);
        if (n > 0) chk("f_dout", f_dout, q[0]);
        chk("s_valid", s_valid, exp_svalid);
        chk("s_dout", s_dout, exp_sdout);
    endtask

    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        logic wa, ra;
        rst = r;
        wr_en = w;
        din = d;
        rd_en = rd;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_ov = 1'b0;
            exp_un = 1'b0;
            exp_svalid = 1'b0;
            exp_sdout = '0;
        end else begin
            wa = w && (q.size() < DEPTH);
            ra = rd && (q.size() > 0);
            exp_ov = w && !wa;
            exp_un = rd && !ra;
            exp_svalid = ra;
            if (ra) exp_sdout = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [DW-1:0] d,
                                input int cnt, input logic ov, input logic un,
                                input logic [DW-1:0] dout);
        vec_t v;
        v.wr = wr;
        v.rd = rd;
        v.din = d;
        v.cnt = cnt;
        v.full = (cnt == DEPTH);
        v.empty = (cnt == 0);
        v.ov = ov;
        v.un = un;
        v.chk_dout = (cnt > 0);
        v.dout = dout;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        din = '0;
        rd_en = 1'b0;
        pft = CW'(12);
        pet = CW'(3);

        // Hand-derived vectors: fill, overflow, simultaneous at full, drain, underflow
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, DW'(i + 1), i + 1, 0, 0, 8'h01));
        tbl.push_back(mk(1, 0, 8'h77, 16, 1, 0, 8'h01));
        tbl.push_back(mk(1, 1, 8'h55, 15, 1, 0, 8'h02));
        for (int i = 0; i < 15; i++) tbl.push_back(mk(0, 1, 8'h00, 14 - i, 0, 0, DW'(i + 3)));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 8'h00));
        tbl.push_back(mk(1, 1, 8'h99, 1, 0, 1, 8'h99));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 8'h00));

        step(1, 1, 8'hEE, 1);
        step(1, 0, 8'h00, 0);
        chk("reset_empty", f_empty, 1'b1);
        chk("reset_std_dout", 32'(s_dout), 32'h0);

        foreach (tbl[i]) begin
            step(0, tbl[i].wr, tbl[i].din, tbl[i].rd);
            chk("tbl_count", 32'(f_cnt), tbl[i].cnt);
            chk("tbl_full", f_full, tbl[i].full);
            chk("tbl_empty", f_empty, tbl[i].empty);
            chk("tbl_overflow", f_ov, tbl[i].ov);
            chk("tbl_underflow", f_un, tbl[i].un);
            chk("tbl_prog_full", f_pf, tbl[i].cnt >= 12);
            chk("tbl_prog_empty", f_pe, tbl[i].cnt <= 3);
            if (tbl[i].chk_dout) chk("tbl_dout", f_dout, tbl[i].dout);
        end

        // Registered read: one read strobe gives one valid cycle, then dout holds
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hAA, 0);
        step(0, 1, 8'hBB, 0);
        step(0, 0, 8'h00, 1);
        chk("std_read_dout", 32'(s_dout), 32'hAA);
        chk("std_read_valid", s_valid, 1'b1);
        step(0, 0, 8'h00, 0);
        chk("std_hold_valid", s_valid, 1'b0);
        chk("std_hold_dout", 32'(s_dout), 32'hAA);

        // Randomized mixed traffic across the pointer wrap, thresholds changing live
        for (int i = 0; i < 400; i++) begin
            if ((i % 50) == 0) begin
                pft = CW'($urandom_range(0, DEPTH));
                pet = CW'($urandom_range(0, DEPTH));
            end
            step(0, ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35)),
                 DW'($urandom), ($urandom_range(0, 99) < 50));
        end

        // Reset at count 7 discards contents and ignores requests in the reset cycle
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) step(0, 1, DW'(8'h30 + i), 0);
        chk("pre_reset_count", 32'(f_cnt), 32'd7);
        step(1, 1, 8'h5A, 1);
        chk("post_reset_count", 32'(f_cnt), 32'd0);
        chk("post_reset_empty", f_empty, 1'b1);
        step(0, 1, 8'hC3, 0);
        chk("post_reset_first", f_dout, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
